// File: rtl/pipe_ctrl_pkg.sv
// pipe_pkg: default geometry, stage and register index constants for pipe_ctrl.
package pipe_pkg;
  localparam int unsigned PIPE_STAGES    = 4;
  localparam int unsigned PIPE_NREGS     = 8;
  localparam int unsigned PIPE_CNT_W     = 3;
  localparam int unsigned PIPE_JMP_STAGE = 1;

  localparam int unsigned STG_AG = 0;
  localparam int unsigned STG_MR = 1;
  localparam int unsigned STG_EX = 2;
  localparam int unsigned STG_MW = 3;

  localparam int unsigned EAX = 0;
  localparam int unsigned ECX = 1;
  localparam int unsigned EDX = 2;
  localparam int unsigned EBX = 3;
  localparam int unsigned ESP = 4;
  localparam int unsigned EBP = 5;
  localparam int unsigned ESI = 6;
  localparam int unsigned EDI = 7;

  function automatic logic [PIPE_NREGS-1:0] reg_mask(input int unsigned idx);
    return PIPE_NREGS'(1) << idx;
  endfunction
endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// pipe_scoreboard: per-register count of in-flight writes; nz flags registers with pending writes.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned NREGS = PIPE_NREGS,
  parameter int unsigned CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             r,
  input  logic [NREGS-1:0] inc_mask,
  input  logic [NREGS-1:0] dec_mask,
  output logic [NREGS-1:0] nz
);
  logic [CNT_W-1:0] pend_q [NREGS];
  logic [CNT_W-1:0] pend_d [NREGS];

  always_comb begin
    for (int unsigned k = 0; k < NREGS; k++) begin
      pend_d[k] = pend_q[k];
      case ({inc_mask[k], dec_mask[k]})
        2'b10:   pend_d[k] = pend_q[k] + CNT_W'(1);
        2'b01:   pend_d[k] = pend_q[k] - CNT_W'(1);
        default: pend_d[k] = pend_q[k];
      endcase
      nz[k] = (pend_q[k] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (r) pend_q[k] <= '0;
      else   pend_q[k] <= pend_d[k];
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stage valids/latch enables, RAW scoreboard and jump-in-flight flag for the in-order pipe.
// Optional PIPE_CTRL_PERF_EN adds retire_cnt/stall_cnt performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES    = PIPE_STAGES,
  parameter int unsigned NREGS     = PIPE_NREGS,
  parameter int unsigned CNT_W     = PIPE_CNT_W,
  parameter int unsigned JMP_STAGE = PIPE_JMP_STAGE
) (
  input  logic              clk,
  input  logic              r,
  input  logic              de_v,
  input  logic [NREGS-1:0]  de_src_mask,
  input  logic [NREGS-1:0]  de_dst_mask,
  input  logic              de_jmp,
  input  logic [STAGES-1:0] stage_stall,
  output logic              issue,
  output logic              ld_de,
  output logic [STAGES-1:0] ld,
  output logic [STAGES-1:0] v,
  output logic              reg_dep,
  output logic              jmp_pend,
  output logic              wb
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  logic [STAGES-1:0]            hold;
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0]            jmp_q, jmp_d;
  logic [STAGES-1:0][NREGS-1:0] dst_q, dst_d;
  logic [NREGS-1:0]             nz, inc_mask, dec_mask;

  always_comb begin
    // A stall anywhere downstream holds every stage at or above it.
    hold = '0;
    for (int unsigned i = 0; i < STAGES; i++) hold[i] = |(stage_stall >> i);
    ld       = ~hold;
    reg_dep  = de_v & |(de_src_mask & nz);
    issue    = de_v & ~reg_dep & ~hold[0];
    ld_de    = ~de_v | issue;
    wb       = v_q[STAGES-1] & ~stage_stall[STAGES-1];
    jmp_pend = de_v & de_jmp;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (i <= JMP_STAGE) jmp_pend = jmp_pend | (v_q[i] & jmp_q[i]);
    end
    inc_mask = issue ? de_dst_mask : '0;
    dec_mask = wb ? dst_q[STAGES-1] : '0;

    v_d   = v_q;
    dst_d = dst_q;
    jmp_d = jmp_q;
    if (ld[0]) begin
      v_d[0]   = issue;
      dst_d[0] = issue ? de_dst_mask : '0;
      jmp_d[0] = issue & de_jmp;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      if (ld[i]) begin
        v_d[i]   = v_q[i-1] & ~hold[i-1];
        dst_d[i] = v_d[i] ? dst_q[i-1] : '0;
        jmp_d[i] = v_d[i] & jmp_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      v_q   <= '0;
      dst_q <= '0;
      jmp_q <= '0;
    end else begin
      v_q   <= v_d;
      dst_q <= dst_d;
      jmp_q <= jmp_d;
    end
  end

  assign v = v_q;

  pipe_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_sb (
    .clk      (clk),
    .r        (r),
    .inc_mask (inc_mask),
    .dec_mask (dec_mask),
    .nz       (nz)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {31'b0, wb};
    stall_cnt_d  = stall_cnt_q + {31'b0, de_v & ~issue};
  end

  always_ff @(posedge clk) begin
    if (r) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against an in-flight instruction list model.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  import pipe_pkg::*;

  localparam int unsigned S  = 4;
  localparam int unsigned N  = 8;
  localparam int unsigned JS = 1;

  logic         clk = 1'b0;
  logic         r;
  logic         de_v;
  logic [N-1:0] de_src_mask, de_dst_mask;
  logic         de_jmp;
  logic [S-1:0] stage_stall;
  logic         issue, ld_de, reg_dep, jmp_pend, wb;
  logic [S-1:0] ld, v;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]  retire_cnt, stall_cnt;
`endif

  pipe_ctrl #(
    .STAGES    (S),
    .NREGS     (N),
    .CNT_W     (3),
    .JMP_STAGE (JS)
  ) dut (
    .clk         (clk),
    .r           (r),
    .de_v        (de_v),
    .de_src_mask (de_src_mask),
    .de_dst_mask (de_dst_mask),
    .de_jmp      (de_jmp),
    .stage_stall (stage_stall),
    .issue       (issue),
    .ld_de       (ld_de),
    .ld          (ld),
    .v           (v),
    .reg_dep     (reg_dep),
    .jmp_pend    (jmp_pend),
    .wb          (wb)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: the list of instructions in flight, each tagged with the stage it occupies.
  typedef struct {
    int unsigned  stage;
    logic [N-1:0] dst;
    logic         jmp;
  } instr_t;

  instr_t       q[$];
  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic         e_issue, e_ldde, e_dep, e_jp, e_wb;
  logic [S-1:0] e_v, e_ld, e_hold;
  logic [31:0]  m_retire = '0;
  logic [31:0]  m_stall  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    logic [N-1:0] busy;
    busy  = '0;
    e_v   = '0;
    e_jp  = de_v & de_jmp;
    foreach (q[j]) begin
      e_v[q[j].stage] = 1'b1;
      busy = busy | q[j].dst;
      if (q[j].stage <= JS && q[j].jmp) e_jp = 1'b1;
    end
    for (int unsigned i = 0; i < S; i++) begin
      e_hold[i] = 1'b0;
      for (int unsigned j = i; j < S; j++) if (stage_stall[j]) e_hold[i] = 1'b1;
    end
    e_ld    = ~e_hold;
    e_dep   = de_v && ((de_src_mask & busy) != '0);
    e_issue = de_v && !e_dep && !e_hold[0];
    e_ldde  = !de_v || e_issue;
    e_wb    = e_v[S-1] && !stage_stall[S-1];
  endfunction

  function automatic void model_step();
    instr_t nq[$];
    instr_t t;
    if (r) begin
      q.delete();
      m_retire = '0;
      m_stall  = '0;
      return;
    end
    if (e_wb) m_retire = m_retire + 32'd1;
    if (de_v && !e_issue) m_stall = m_stall + 32'd1;
    foreach (q[j]) begin
      t = q[j];
      if (t.stage == S-1) begin
        if (stage_stall[S-1]) nq.push_back(t);
      end else begin
        if (!e_hold[t.stage]) t.stage++;
        nq.push_back(t);
      end
    end
    if (e_issue) begin
      t.stage = 0;
      t.dst   = de_dst_mask;
      t.jmp   = de_jmp;
      nq.push_back(t);
    end
    q = nq;
  endfunction

  task automatic compare();
    int unsigned cnt;
    chk("issue", 32'(issue), 32'(e_issue));
    chk("ld_de", 32'(ld_de), 32'(e_ldde));
    chk("ld", 32'(ld), 32'(e_ld));
    chk("v", 32'(v), 32'(e_v));
    chk("reg_dep", 32'(reg_dep), 32'(e_dep));
    chk("jmp_pend", 32'(jmp_pend), 32'(e_jp));
    chk("wb", 32'(wb), 32'(e_wb));
`ifdef PIPE_CTRL_PERF_EN
    chk("retire_cnt", retire_cnt, m_retire);
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    for (int unsigned k = 0; k < N; k++) begin
      cnt = 0;
      foreach (q[j]) if (q[j].dst[k]) cnt++;
      chk("pend_bound", 32'(cnt <= S), 32'd1);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    compare();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    sample();
    step();
  endtask

  task automatic set_de(input logic val, input logic [N-1:0] src, input logic [N-1:0] dst,
                        input logic j);
    de_v        = val;
    de_src_mask = src;
    de_dst_mask = dst;
    de_jmp      = j;
  endtask

  task automatic drain();
    set_de(1'b0, '0, '0, 1'b0);
    stage_stall = '0;
    repeat (S + 2) tick();
  endtask

  task automatic new_decode();
    de_v        = ($urandom % 10) < 7;
    de_src_mask = N'($urandom & $urandom & $urandom);
    de_dst_mask = ($urandom % 3 == 0) ? '0 : reg_mask($urandom % N);
    de_jmp      = ($urandom % 10) == 0;
  endtask

  initial begin
    r = 1'b1;
    set_de(1'b0, '0, '0, 1'b0);
    stage_stall = '0;
    #1;
    tick();
    tick();
    r = 1'b0;

    // Reset state
    sample();
    chk("rst_v", 32'(v), 32'h0);
    chk("rst_wb", 32'(wb), 32'h0);
    chk("rst_ld", 32'(ld), 32'hF);
    chk("rst_dep", 32'(reg_dep), 32'h0);
    chk("rst_jp", 32'(jmp_pend), 32'h0);
    step();

    // Single EAX writer walks the pipe; a dependent reader waits for it.
    set_de(1'b1, '0, reg_mask(EAX), 1'b0);
    sample();
    chk("single_issue", 32'(issue), 32'h1);
    step();
    set_de(1'b1, reg_mask(EAX), '0, 1'b0);
    for (int unsigned c = 0; c < 4; c++) begin
      sample();
      chk("single_v", 32'(v), 32'(1) << c);
      chk("single_dep", 32'(reg_dep), 32'h1);
      chk("single_wb", 32'(wb), 32'(c == 3));
      step();
    end
    sample();
    chk("single_cons_issue", 32'(issue), 32'h1);
    chk("single_v_empty", 32'(v), 32'h0);
    step();
    drain();

    // RAW on EDX
    set_de(1'b1, '0, 8'h04, 1'b0);
    tick();
    set_de(1'b1, 8'h04, '0, 1'b0);
    repeat (4) begin
      sample();
      chk("raw_dep", 32'(reg_dep), 32'h1);
      chk("raw_hold", 32'(issue), 32'h0);
      step();
    end
    sample();
    chk("raw_issue", 32'(issue), 32'h1);
    step();
    drain();

    // Fill all stages, then stall MR for 3 cycles
    set_de(1'b1, '0, '0, 1'b0);
    repeat (4) tick();
    stage_stall = 4'b0010;
    for (int unsigned c = 0; c < 3; c++) begin
      sample();
      chk("stall_ld", 32'(ld), 32'hC);
      chk("stall_issue", 32'(issue), 32'h0);
      chk("stall_v", 32'(v), (c == 0) ? 32'hF : ((c == 1) ? 32'hB : 32'h3));
      step();
    end
    drain();

    // Jump: pending from decode until it reaches EX
    set_de(1'b1, '0, '0, 1'b1);
    sample();
    chk("jmp_de", 32'(jmp_pend), 32'h1);
    step();
    set_de(1'b0, '0, '0, 1'b0);
    for (int unsigned c = 0; c < 3; c++) begin
      sample();
      chk("jmp_pipe", 32'(jmp_pend), 32'(c < 2));
      step();
    end
    drain();

    // Reset with three ECX writers in flight
    set_de(1'b1, '0, reg_mask(ECX), 1'b0);
    repeat (3) tick();
    r = 1'b1;
    tick();
    r = 1'b0;
    set_de(1'b1, reg_mask(ECX), '0, 1'b0);
    sample();
    chk("rst_mid_v", 32'(v), 32'h0);
    chk("rst_mid_wb", 32'(wb), 32'h0);
    chk("rst_mid_dep", 32'(reg_dep), 32'h0);
    chk("rst_mid_issue", 32'(issue), 32'h1);
    step();
    drain();

    // Simultaneous wb and issue on EAX
    set_de(1'b1, '0, reg_mask(EAX), 1'b0);
    tick();
    set_de(1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    set_de(1'b1, '0, reg_mask(EAX), 1'b0);
    sample();
    chk("sim_wb", 32'(wb), 32'h1);
    chk("sim_issue", 32'(issue), 32'h1);
    step();
    set_de(1'b1, reg_mask(EAX), '0, 1'b0);
    sample();
    chk("sim_pend", 32'(reg_dep), 32'h1);
`ifdef PIPE_CTRL_PERF_EN
    chk("sim_retire", retire_cnt, 32'd2);
`endif
    step();
    drain();

    // Randomized traffic
    new_decode();
    for (int unsigned c = 0; c < 3000; c++) begin
      stage_stall = S'($urandom & $urandom & $urandom);
      r = ($urandom % 300) == 0;
      sample();
      step();
      if (e_ldde || r) new_decode();
    end
    r = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control block for the in-order x86 datapath. It sits beside decode and owns everything the stage latches need besides data:
- per-stage valid bits and latch enables, with stall propagation from any stage;
- a per-register pending-write scoreboard that replaces the fixed four-stage modrm comparator chains;
- a control-transfer-in-flight flag that holds fetch.

Stage count, register count and jump-resolve stage are parameters.

## Interface

Parameters:
- STAGES, 4, number of post-decode stages (0=AG, 1=MR, 2=EX, 3=MW).
- NREGS, 8, architectural registers tracked by the scoreboard.
- CNT_W, 3, scoreboard counter width; must satisfy 2^CNT_W > STAGES.
- JMP_STAGE, 1, stage index at which a control transfer loads EIP/CS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- r  in  1  reset, synchronous, active-high.
- de_v  in  1  decode latch holds a valid instruction.
- de_src_mask  in  NREGS  registers read by the decode instruction.
- de_dst_mask  in  NREGS  registers written by the decode instruction (zero or one-hot).
- de_jmp  in  1  decode instruction is a control transfer.
- stage_stall  in  STAGES  per-stage stall request (e.g. mr_stall at bit 1, mw_stall at bit 3).
- issue  out  1  decode instruction enters stage 0 this cycle.
- ld_de  out  1  decode latch may load from fetch.
- ld  out  STAGES  per-stage latch enable.
- v  out  STAGES  per-stage valid.
- reg_dep  out  1  decode held on a RAW hazard.
- jmp_pend  out  1  control transfer in decode or stages 0..JMP_STAGE; fetch must not present a new valid instruction.
- wb  out  1  last stage holds a valid, non-stalled instruction; register/flag writeback happens this cycle.

## Operation

- hold[STAGES-1] = stage_stall[STAGES-1].
- hold[i] = stage_stall[i] | hold[i+1].
- ld[i] = ~hold[i].
- Stage input valid:
  - Stage 0 takes issue.
  - Stage i>0 takes v[i-1] & ~hold[i-1]. A stalled upstream stage injects a bubble.
- Per-stage sideband registers dst[i] (NREGS) and jmp[i] (1) move with v under ld[i]. They are cleared to 0 whenever the loaded valid is 0.
- reg_dep = de_v & |(de_src_mask & nz), where nz[k] = (pend[k] != 0).
- issue = de_v & ~reg_dep & ~hold[0].
- ld_de = ~de_v | issue.
- wb = v[STAGES-1] & ~stage_stall[STAGES-1].
- Scoreboard pend[k], per register k:
  - Increment on issue & de_dst_mask[k].
  - Decrement on wb & dst[STAGES-1][k].
  - Simultaneous increment and decrement: unchanged.
- A register written in the wb cycle is still pending in that cycle. A dependent instruction in decode issues the following cycle. Regfile write-then-read ordering is therefore never relied on.
- jmp_pend = (de_v & de_jmp) | OR over i ≤ JMP_STAGE of (v[i] & jmp[i]).
- Counters never overflow because at most STAGES writes are in flight. Bench asserts pend[k] ≤ STAGES and no decrement at 0.

## Timing

- Reset values: v=0, dst=0, jmp=0, pend=0. Combinational outputs follow from these: wb=0, reg_dep=0, jmp_pend=de_v&de_jmp, ld=all-ones when stage_stall=0.
- Reset mid-operation discards all in-flight instructions and zeroes every counter in the same edge. It overrides issue and wb in that cycle.
- Latency: issue at cycle n, then in stage i at cycle n+1+i, with wb at cycle n+STAGES when there are no stalls.
- Dependent back-to-back instructions: the consumer issues STAGES+1 cycles after the producer.
- All outputs are combinational from current state and inputs. There is no registered output latency.

## Configuration

- PIPE_CTRL_PERF_EN defined: adds outputs retire_cnt (32) and stall_cnt (32).
  - retire_cnt counts wb cycles.
  - stall_cnt counts cycles with de_v & ~issue.
  - Both reset to 0 and wrap modulo 2^32.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent and all other behaviour is identical.

## Structure

- Package pipe_pkg:
  - default STAGES/NREGS/CNT_W;
  - stage index constants STG_AG=0, STG_MR=1, STG_EX=2, STG_MW=3;
  - register index constants EAX..EDI.
- Sub-module pipe_scoreboard: NREGS counters of CNT_W bits, with inputs inc_mask/dec_mask and output nz. Instantiated once.

## Test plan

- Single instruction, dst=EAX (mask 0x01), no stalls: issue at cycle 1, then v walks 0001→0010→0100→1000, then wb at cycle 5. pend[0] is 1 for cycles 2..5 and 0 at cycle 6.
- RAW hazard: producer dst=0x04, next instruction src=0x04. reg_dep=1 for 4 cycles, then the consumer issues the cycle after the producer's wb.
- stage_stall[1]=1 for 3 cycles with all stages valid: ld=1100 for those cycles, v[2] becomes 0 (bubble), stages 0/1 retain their contents, issue=0.
- Jump in decode with JMP_STAGE=1: jmp_pend=1 from decode through the cycle the jump sits in MR, and deasserts the cycle it reaches EX.
- Reset asserted with 3 valid instructions, each writing ECX: next cycle v=0000, pend[1]=0, wb=0.
- Simultaneous wb and issue on the same register (EAX): pend[0] stays 1. With PIPE_CTRL_PERF_EN, retire_cnt increments by exactly 1.
